// File: rtl/board_io_pkg.sv
// Board-level I/O constants shared by the input conditioner and its consumers.
// Debounce length is derived from the board clock so a clock change only touches CLK_HZ.
package board_io_pkg;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned SYNC_STAGES     = 2;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned NUM_SW  = 4;
  localparam int unsigned NUM_CH  = NUM_BTN + NUM_SW;

  // Bit positions inside raw_in / level / rise / fall.
  localparam int unsigned CH_BTN0 = 0;
  localparam int unsigned CH_BTN1 = 1;
  localparam int unsigned CH_BTN2 = 2;
  localparam int unsigned CH_BTN3 = 3;
  localparam int unsigned CH_SW0  = 4;
  localparam int unsigned CH_SW1  = 5;
  localparam int unsigned CH_SW2  = 6;
  localparam int unsigned CH_SW3  = 7;

endpackage

// File: rtl/board_input_conditioner_debounce_bit.sv
// One conditioned channel: SYNC_STAGES-flop synchronizer, disagreement counter,
// registered stable level and single-cycle rise/fall pulses.
module debounce_bit #(
  parameter int unsigned SYNC_STAGES     = board_io_pkg::SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  import board_io_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter only runs while the synchronized pin disagrees with the level;
  // reaching CNT_LAST commits the flip, so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_s;
        r_cnt   <= '0;
        r_rise  <= w_s;
        r_fall  <= ~w_s;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions the board buttons (raw_in[3:0]) and switches (raw_in[7:4]) into
// clean levels and edge pulses; changed flags any edge on any channel.
module board_input_conditioner #(
  parameter int unsigned N_CH            = board_io_pkg::NUM_CH,
  parameter int unsigned SYNC_STAGES     = board_io_pkg::SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = board_io_pkg::DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            changed
);
  import board_io_pkg::*;

  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (raw_in[g]),
      .o_level(level[g]),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  // Pulses are already registered per channel, so the OR lands in the same cycle.
  assign rise    = w_rise;
  assign fall    = w_fall;
  assign changed = |(w_rise | w_fall);

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: sliding-window reference model checked every
// cycle, directed scenarios with literal expectations, then randomized pin activity.
module tb_board_input_conditioner;
  localparam int N = 8;
  localparam int S = 2;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw_in;
  logic [N-1:0] level, rise, fall;
  logic         changed;

  int errors = 0;
  int checks = 0;

  board_input_conditioner #(
    .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in),
    .level(level), .rise(rise), .fall(fall), .changed(changed)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the pin value seen by the debouncer is the pad sampled S edges
  // earlier; a channel flips when the last D seen values all oppose its level.
  logic [N-1:0] m_pipe [S];
  logic [N-1:0] m_win [$];
  logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0;
  bit           m_valid = 0;

  always @(posedge clk) begin
    logic [N-1:0] s;
    bit           all_opp;
    if (rst) begin
      for (int i = 0; i < S; i++) m_pipe[i] = '0;
      m_win.delete();
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
    end else begin
      s = m_pipe[S-1];
      for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = raw_in;
      m_win.push_back(s);
      if (m_win.size() > D) void'(m_win.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (m_win.size() == D) begin
        for (int ch = 0; ch < N; ch++) begin
          all_opp = 1;
          foreach (m_win[k]) if (m_win[k][ch] == m_level[ch]) all_opp = 0;
          if (all_opp) begin
            m_level[ch] = ~m_level[ch];
            if (m_level[ch]) m_rise[ch] = 1'b1;
            else             m_fall[ch] = 1'b1;
          end
        end
      end
    end
    m_valid = 1;
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_level",   level, m_level);
      check("model_rise",    rise,  m_rise);
      check("model_fall",    fall,  m_fall);
      check("model_changed", {{(N-1){1'b0}}, changed}, {{(N-1){1'b0}}, |(m_rise | m_fall)});
    end
  end

  // pulse counters, updated just after each edge so they are stable at negedge
  int rise_cnt [N];
  int fall_cnt [N];
  int chg_cnt = 0;
  initial for (int i = 0; i < N; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rise[i] === 1'b1) rise_cnt[i]++;
      if (fall[i] === 1'b1) fall_cnt[i]++;
    end
    if (changed === 1'b1) chg_cnt++;
  end

  int snap_r, snap_f, snap_c;

  initial begin
    // 1: reset, quiet pins
    rst = 1'b1;
    raw_in = '0;
    wait_neg(3);
    check("reset_level", level, 8'h00);
    check("reset_rise",  rise,  8'h00);
    rst = 1'b0;
    snap_c = chg_cnt;
    wait_neg(100);
    check("idle_level", level, 8'h00);
    check("idle_changed_count", 8'(chg_cnt - snap_c), 8'd0);

    // 2: clean step on btn0
    raw_in[0] = 1'b1;
    wait_neg(17);
    check("step_level_before", level, 8'h00);
    wait_neg(1);
    check("step_level", level, 8'h01);
    check("step_rise",  rise,  8'h01);
    check("step_changed", {7'd0, changed}, 8'd1);
    wait_neg(1);
    check("step_rise_gone", rise, 8'h00);
    check("step_changed_gone", {7'd0, changed}, 8'd0);

    // 3: short glitch rejected, long enough press accepted
    snap_r = rise_cnt[1];
    raw_in[1] = 1'b1;
    wait_neg(15);
    raw_in[1] = 1'b0;
    wait_neg(30);
    check("glitch15_level", level, 8'h01);
    check("glitch15_rises", 8'(rise_cnt[1] - snap_r), 8'd0);
    raw_in[1] = 1'b1;
    wait_neg(16);
    raw_in[1] = 1'b0;
    wait_neg(2);
    check("hold16_level", level, 8'h03);
    check("hold16_rises", 8'(rise_cnt[1] - snap_r), 8'd1);
    wait_neg(30);

    // 4: chatter on btn2, then settle high
    snap_r = rise_cnt[2];
    snap_f = fall_cnt[2];
    for (int seg = 0; seg < 20; seg++) begin
      raw_in[2] = (seg % 2 == 0);
      wait_neg(3);
    end
    raw_in[2] = 1'b1;
    wait_neg(17);
    check("chatter_level_before", level, 8'h01);
    wait_neg(1);
    check("chatter_level", level, 8'h05);
    check("chatter_rises", 8'(rise_cnt[2] - snap_r), 8'd1);
    check("chatter_falls", 8'(fall_cnt[2] - snap_f), 8'd0);
    wait_neg(5);

    // 5: btn3 and sw3 together
    snap_c = chg_cnt;
    raw_in[3] = 1'b1;
    raw_in[7] = 1'b1;
    wait_neg(18);
    check("dual_rise", rise, 8'h88);
    check("dual_level", level, 8'h8d);
    wait_neg(1);
    check("dual_changed_count", 8'(chg_cnt - snap_c), 8'd1);
    raw_in[3] = 1'b0;
    raw_in[7] = 1'b0;
    wait_neg(18);
    check("dual_fall", fall, 8'h88);
    check("dual_fall_changed", {7'd0, changed}, 8'd1);
    wait_neg(5);

    // 6: reset in the middle of a count on sw0
    snap_r = rise_cnt[4];
    raw_in[4] = 1'b1;
    wait_neg(10);
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    check("midrst_level", level, 8'h00);
    wait_neg(17);
    check("midrst_level_before", level, 8'h00);
    check("midrst_no_rise_yet", 8'(rise_cnt[4] - snap_r), 8'd0);
    wait_neg(1);
    check("midrst_rise", rise, 8'h15);
    check("midrst_level_after", level, 8'h15);

    // randomized pin activity with occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 19) == 0) raw_in[ch] = ~raw_in[ch];
      rst = ($urandom_range(0, 599) == 0);
      wait_neg(1);
    end
    rst = 1'b0;
    wait_neg(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
